pipeline_register_em_param: RTL and testbench



---
 rtl/pipeline_register_em_param_if.sv | 51 +++++
 rtl/pipeline_register_em_param.sv | 113 +++++++++++
 tb/tb_pipeline_register_em_param.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_register_em_param_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_register_em_param_if
// Brief    : Execute->Memory bundle: E-side fields, hazard controls, M-side fields.
// Revision : 1.0
// ============================================================================
interface pipeline_register_em_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 2
);
    logic              stall;
    logic              flush;

    logic              Evalid;
    logic [DATA_W-1:0] Ehi;
    logic [DATA_W-1:0] Elo;
    logic [DATA_W-1:0] Ealu;
    logic [DATA_W-1:0] Edmwrite;
    logic [DATA_W-1:0] Emodout;
    logic              Emod;
    logic              Ewe3;
    logic              Ewe;
    logic [SEL_W-1:0]  Eregdata;
    logic [ADDR_W-1:0] Ewriteadd;

    logic              Mvalid;
    logic [DATA_W-1:0] Mhi;
    logic [DATA_W-1:0] Mlo;
    logic [DATA_W-1:0] Malu;
    logic [DATA_W-1:0] Mdmwrite;
    logic [DATA_W-1:0] Mmodout;
    logic              Mmod;
    logic              Mwe3;
    logic              Mwe;
    logic [SEL_W-1:0]  Mregdata;
    logic [ADDR_W-1:0] Mwriteadd;

    modport master (
        output stall, flush,
        output Evalid, Ehi, Elo, Ealu, Edmwrite, Emodout, Emod, Ewe3, Ewe, Eregdata, Ewriteadd,
        input  Mvalid, Mhi, Mlo, Malu, Mdmwrite, Mmodout, Mmod, Mwe3, Mwe, Mregdata, Mwriteadd
    );

    modport slave (
        input  stall, flush,
        input  Evalid, Ehi, Elo, Ealu, Edmwrite, Emodout, Emod, Ewe3, Ewe, Eregdata, Ewriteadd,
        output Mvalid, Mhi, Mlo, Malu, Mdmwrite, Mmodout, Mmod, Mwe3, Mwe, Mregdata, Mwriteadd
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_register_em_param.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_register_em_param
// Brief    : STAGES-deep E->M register with valid, stall and flush.
//            Define EM_PERF_CNT_EN to add saturating stall/flush counters.
// Revision : 1.0
// ============================================================================
module pipeline_register_em_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 2,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  wire                         clk,
    input  wire                         reset,
`ifdef EM_PERF_CNT_EN
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt,
`endif
    pipeline_register_em_param_if.slave bus
);

    localparam int c_PAY_W = 5*DATA_W + 3 + SEL_W + ADDR_W;

    logic [c_PAY_W-1:0] w_e_pay;
    logic [STAGES-1:0]  w_valid_vec;
    logic [c_PAY_W-1:0] w_pay_vec [STAGES];

    logic               w_mod;
    logic               w_we3;
    logic               w_we;

    generate
        if (STAGES < 1 || STAGES > 4 || CNT_W < 1) begin : g_bad_cfg
            $error("pipeline_register_em_param: STAGES must be 1..4 and CNT_W >= 1");
        end
    endgenerate

    assign w_e_pay = {bus.Ehi, bus.Elo, bus.Ealu, bus.Edmwrite, bus.Emodout,
                      bus.Emod, bus.Ewe3, bus.Ewe, bus.Eregdata, bus.Ewriteadd};

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic               r_valid;
            logic [c_PAY_W-1:0] r_pay;
            logic               w_valid_in;
            logic [c_PAY_W-1:0] w_pay_in;

            if (k == 0) begin : g_head
                assign w_valid_in = bus.Evalid;
                assign w_pay_in   = w_e_pay;
            end else begin : g_body
                assign w_valid_in = w_valid_vec[k-1];
                assign w_pay_in   = w_pay_vec[k-1];
            end

            // Flush only drops valid; payload is left as-is since it is masked downstream.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_pay   <= '0;
                end else if (bus.flush) begin
                    r_valid <= 1'b0;
                end else if (!bus.stall) begin
                    r_valid <= w_valid_in;
                    r_pay   <= w_pay_in;
                end
            end

            assign w_valid_vec[k] = r_valid;
            assign w_pay_vec[k]   = r_pay;
        end
    endgenerate

    assign {bus.Mhi, bus.Mlo, bus.Malu, bus.Mdmwrite, bus.Mmodout,
            w_mod, w_we3, w_we, bus.Mregdata, bus.Mwriteadd} = w_pay_vec[STAGES-1];

    assign bus.Mvalid = w_valid_vec[STAGES-1];
    assign bus.Mmod   = w_mod & w_valid_vec[STAGES-1];
    assign bus.Mwe3   = w_we3 & w_valid_vec[STAGES-1];
    assign bus.Mwe    = w_we  & w_valid_vec[STAGES-1];

`ifdef EM_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall && !bus.flush && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            // Only flushes that actually kill an instruction are counted.
            if (bus.flush && (|w_valid_vec) && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    // No performance counters in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_register_em_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_register_em_param
// Brief    : Self-checking bench: vector table with latency scoreboard plus
//            stall, flush, reset and counter sequences.
// Revision : 1.0
// ============================================================================
module tb_pipeline_register_em_param;

    localparam int c_STAGES = 3;
    localparam int c_CNT_W  = 4;

    typedef struct packed {
        logic        valid;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] alu;
        logic [15:0] dmw;
        logic [15:0] modout;
        logic        mod;
        logic        we3;
        logic        we;
        logic [1:0]  regdata;
        logic [3:0]  wadd;
    } op_t;

    typedef struct {
        op_t stim;
        op_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    op_t  sb [$];

    always #5 clk = ~clk;

    pipeline_register_em_param_if #(.DATA_W(16), .ADDR_W(4), .SEL_W(2)) bus ();

`ifdef EM_PERF_CNT_EN
    logic [c_CNT_W-1:0] stall_cnt;
    logic [c_CNT_W-1:0] flush_cnt;
`endif

    pipeline_register_em_param #(
        .DATA_W(16), .ADDR_W(4), .SEL_W(2), .STAGES(c_STAGES), .CNT_W(c_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef EM_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    function automatic op_t mk(input logic v, input logic [15:0] alu, input logic we3,
                               input logic we, input logic md, input logic [3:0] wa);
        op_t o;
        o.valid   = v;
        o.hi      = alu ^ 16'h0F0F;
        o.lo      = ~alu;
        o.alu     = alu;
        o.dmw     = alu + 16'd1;
        o.modout  = {alu[14:0], 1'b0};
        o.mod     = md;
        o.we3     = we3;
        o.we      = we;
        o.regdata = wa[1:0];
        o.wadd    = wa;
        return o;
    endfunction

    // Enables are masked when the carrying stage is not valid.
    function automatic op_t gate(input op_t o);
        op_t r = o;
        if (!r.valid) begin
            r.mod = 1'b0;
            r.we3 = 1'b0;
            r.we  = 1'b0;
        end
        return r;
    endfunction

    function automatic op_t sample();
        op_t o;
        o.valid   = bus.Mvalid;
        o.hi      = bus.Mhi;
        o.lo      = bus.Mlo;
        o.alu     = bus.Malu;
        o.dmw     = bus.Mdmwrite;
        o.modout  = bus.Mmodout;
        o.mod     = bus.Mmod;
        o.we3     = bus.Mwe3;
        o.we      = bus.Mwe;
        o.regdata = bus.Mregdata;
        o.wadd    = bus.Mwriteadd;
        return o;
    endfunction

    task automatic drive(input op_t o);
        bus.Evalid    = o.valid;
        bus.Ehi       = o.hi;
        bus.Elo       = o.lo;
        bus.Ealu      = o.alu;
        bus.Edmwrite  = o.dmw;
        bus.Emodout   = o.modout;
        bus.Emod      = o.mod;
        bus.Ewe3      = o.we3;
        bus.Ewe       = o.we;
        bus.Eregdata  = o.regdata;
        bus.Ewriteadd = o.wadd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_op(input string name, input op_t exp);
        op_t act;
        act = sample();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        op_t  zero;
        op_t  a;
        op_t  b;
        op_t  g;
        op_t  gi;
        op_t  n;
        op_t  first;
        vec_t tbl [8];
        int   exp_stall;
        int   exp_flush;

        zero = '0;
        tbl[0].stim = mk(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 4'h1);
        tbl[1].stim = mk(1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 4'h2);
        tbl[2].stim = mk(1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 4'h3);
        tbl[3].stim = mk(1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 4'hF);
        tbl[4].stim = mk(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h0);
        tbl[5].stim = mk(1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, 4'h7);
        tbl[6].stim = mk(1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0, 4'hE);
        tbl[7].stim = mk(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 8; i++) tbl[i].exp = gate(tbl[i].stim);

        // Reset with live-looking inputs: everything must read zero.
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(mk(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b1, 4'hF));
        step();
        step();
        check_op("reset_outputs", zero);
`ifdef EM_PERF_CNT_EN
        check_val("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check_val("reset_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
        reset = 1'b0;

        // Single op latency: exactly c_STAGES edges.
        a = mk(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 4'h5);
        drive(a);
        step();
        drive(zero);
        for (int k = 1; k <= c_STAGES; k++) begin
            if (k > 1) step();
            check_op((k < c_STAGES) ? "latency_early" : "latency_out", (k < c_STAGES) ? zero : a);
        end

        // Back-to-back vectors through a fixed-latency scoreboard.
        sb.delete();
        for (int k = 0; k < c_STAGES - 1; k++) sb.push_back(zero);
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].stim);
            sb.push_back(tbl[i].exp);
            step();
            check_op($sformatf("vec%0d", i), sb.pop_front());
        end
        for (int k = 0; k < c_STAGES - 1; k++) begin
            drive(zero);
            sb.push_back(zero);
            step();
            check_op("vec_drain", sb.pop_front());
        end

        // Stall for 4 cycles with an op in stage0; new E inputs must be ignored.
        b = mk(1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0, 4'h3);
        drive(b);
        step();
        check_op("stall_load", (c_STAGES == 1) ? b : zero);
        bus.stall = 1'b1;
        drive(mk(1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 4'hC));
        for (int k = 0; k < 4; k++) begin
            step();
            check_op("stall_hold", (c_STAGES == 1) ? b : zero);
        end
        bus.stall = 1'b0;
        drive(zero);
        for (int k = 1; k <= c_STAGES - 1; k++) begin
            step();
            check_op((k < c_STAGES - 1) ? "stall_early" : "stall_out", (k < c_STAGES - 1) ? zero : b);
        end
        step();
        check_op("stall_after", zero);

        // Flush (with and without stall) over a pipeline full of store ops.
        g = mk(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 4'h9);
        drive(g);
        repeat (c_STAGES) step();
        check_op("flush_full", g);
        gi       = g;
        gi.valid = 1'b0;
        gi       = gate(gi);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive(mk(1'b1, 16'h7777, 1'b1, 1'b1, 1'b1, 4'h2));
        step();
        check_op("flush_over_stall", gi);
        bus.stall = 1'b0;
        step();
        check_op("flush_drop_e", gi);
        bus.flush = 1'b0;
        drive(zero);
        for (int k = 1; k <= c_STAGES - 1; k++) begin
            step();
            check_op("flush_drain", gi);
        end
        step();
        check_op("flush_clear", zero);

        // Reset while full of valid ops, then restart.
        first = mk(1'b1, 16'h1000, 1'b1, 1'b1, 1'b0, 4'h4);
        for (int k = 0; k < c_STAGES; k++) begin
            drive(mk(1'b1, 16'(16'h1000 + k), 1'b1, 1'b1, 1'b0, 4'h4));
            step();
        end
        check_op("full_before_reset", first);
        reset = 1'b1;
        drive(mk(1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, 4'h6));
        step();
        check_op("reset_midstream", zero);
        reset = 1'b0;
        n = mk(1'b1, 16'h4321, 1'b0, 1'b1, 1'b1, 4'hA);
        drive(n);
        step();
        drive(zero);
        for (int k = 1; k <= c_STAGES; k++) begin
            if (k > 1) step();
            check_op((k < c_STAGES) ? "post_reset_early" : "post_reset_out", (k < c_STAGES) ? zero : n);
        end

`ifdef EM_PERF_CNT_EN
        exp_stall = 0;
        exp_flush = 0;
        check_val("cnt_after_reset_stall", 32'(stall_cnt), 32'(exp_stall));
        bus.stall = 1'b1;
        drive(mk(1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 4'h1));
        for (int k = 0; k < 20; k++) begin
            step();
            if (exp_stall < (1 << c_CNT_W) - 1) exp_stall++;
            if (k == 9) check_val("stall_cnt_mid", 32'(stall_cnt), 32'(exp_stall));
        end
        check_val("stall_cnt_sat", 32'(stall_cnt), 32'(exp_stall));
        bus.stall = 1'b0;
        drive(zero);
        repeat (c_STAGES) step();
        bus.flush = 1'b1;
        step();
        check_val("flush_cnt_empty", 32'(flush_cnt), 32'(exp_flush));
        bus.flush = 1'b0;
        drive(mk(1'b1, 16'h0042, 1'b1, 1'b0, 1'b0, 4'h2));
        step();
        drive(zero);
        bus.flush = 1'b1;
        step();
        exp_flush++;
        check_val("flush_cnt_one_valid", 32'(flush_cnt), 32'(exp_flush));
        step();
        check_val("flush_cnt_again_empty", 32'(flush_cnt), 32'(exp_flush));
        check_val("stall_cnt_kept", 32'(stall_cnt), 32'(exp_stall));
        bus.flush = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
